// File: rtl/dh_dw_sched_pkg.sv
// ---------------------------------------------------------------------------
// dh_dw_sched_pkg
// Shared definitions for the GRU dh/dW gradient sequencer:
//   DATABIT  - signed fixed-point width of unit results and gradient bank
//   ST_*     - sequencer state encodings
//   sat_add  - DATABIT-wide signed add that clamps instead of wrapping
// ---------------------------------------------------------------------------
package dh_dw_sched_pkg;

  localparam int DATABIT = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Sum in DATABIT+1 bits; if the two top bits disagree the true result
  // left the representable range, so clamp toward the sign of the sum.
  function automatic logic signed [DATABIT-1:0] sat_add(
    input logic signed [DATABIT-1:0] a,
    input logic signed [DATABIT-1:0] b
  );
    logic signed [DATABIT:0] s;
    s = {a[DATABIT-1], a} + {b[DATABIT-1], b};
    if (s[DATABIT] != s[DATABIT-1])
      sat_add = s[DATABIT] ? {1'b1, {(DATABIT-1){1'b0}}}
                           : {1'b0, {(DATABIT-1){1'b1}}};
    else
      sat_add = s[DATABIT-1:0];
  endfunction

endpackage

// File: rtl/dh_dw_sched_acc_bank.sv
// ---------------------------------------------------------------------------
// dh_acc_bank
// 4x4 bank of saturating gradient accumulators.
//   clk, rst_n       - clock, asynchronous active-low reset (bank -> 0)
//   clr              - synchronous clear of all 16 entries
//   wr_en, wr_row    - accumulate wr_r0..wr_r3 into row wr_row
//   rd_addr/rd_data  - combinational read, address {row[1:0], lane[1:0]}
// ---------------------------------------------------------------------------
module dh_acc_bank
  import dh_dw_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [1:0]                wr_row,
  input  logic signed [DATABIT-1:0] wr_r0,
  input  logic signed [DATABIT-1:0] wr_r1,
  input  logic signed [DATABIT-1:0] wr_r2,
  input  logic signed [DATABIT-1:0] wr_r3,
  input  logic [3:0]                rd_addr,
  output logic signed [DATABIT-1:0] rd_data
);

  logic signed [DATABIT-1:0] bank_reg [16];
  logic signed [DATABIT-1:0] acc_next [16];
  logic signed [DATABIT-1:0] lane_val [4];

  assign lane_val[0] = wr_r0;
  assign lane_val[1] = wr_r1;
  assign lane_val[2] = wr_r2;
  assign lane_val[3] = wr_r3;

  // Every entry precomputes its saturated sum; only the addressed row commits.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_entry
      assign acc_next[gi] = sat_add(bank_reg[gi], lane_val[gi % 4]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank_reg[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 16; i++) bank_reg[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 16; i++)
        if (wr_row == 2'(i / 4)) bank_reg[i] <= acc_next[i];
    end
  end

  assign rd_data = bank_reg[rd_addr];

endmodule

// File: rtl/dh_dw_sched.sv
// ---------------------------------------------------------------------------
// dh_dw_sched
// Sequencer for the GRU dh/dW gradient unit. Per timestep it fetches operands
// (op_req/op_ack), then for n = 0..3 issues the unit (dp_en/dp_n), waits for
// dp_valid and accumulates dp_r0..dp_r3 into row n of a 4x4 saturating bank.
//   start/clr_acc/t_len      - control, honoured only while idle
//   op_req/op_t/op_ack       - operand fetch handshake
//   dp_en/dp_n/dp_valid/dp_r*- gradient unit interface
//   busy/done/err_timeout    - status (err_timeout sticky until next start)
//   rd_addr/rd_data          - bank read port, {n, lane}
// ---------------------------------------------------------------------------
module dh_dw_sched
  import dh_dw_sched_pkg::*;
#(
  parameter int T_W     = 6,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      clr_acc,
  input  logic [T_W-1:0]            t_len,
  output logic                      op_req,
  output logic [T_W-1:0]            op_t,
  input  logic                      op_ack,
  output logic                      dp_en,
  output logic [1:0]                dp_n,
  input  logic                      dp_valid,
  input  logic signed [DATABIT-1:0] dp_r0,
  input  logic signed [DATABIT-1:0] dp_r1,
  input  logic signed [DATABIT-1:0] dp_r2,
  input  logic signed [DATABIT-1:0] dp_r3,
  output logic                      busy,
  output logic                      done,
  output logic                      err_timeout,
  input  logic [3:0]                rd_addr,
  output logic signed [DATABIT-1:0] rd_data
);

  logic [2:0]      state_reg;
  logic [T_W-1:0]  t_reg;
  logic [T_W-1:0]  tlen_reg;
  logic [1:0]      n_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;

  logic bank_clr;
  logic bank_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      t_reg      <= '0;
      tlen_reg   <= '0;
      n_reg      <= '0;
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            tlen_reg  <= t_len;
            err_reg   <= 1'b0;
            t_reg     <= '0;
            n_reg     <= '0;
            state_reg <= (t_len == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (op_ack) state_reg <= ST_ISSUE;
        end
        ST_ISSUE: begin
          to_cnt_reg <= '0;
          state_reg  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A valid already high on entry is a fresh result: DRAIN guarantees
          // the previous job's level has dropped before the next ISSUE.
          if (dp_valid) begin
            state_reg <= ST_DRAIN;
          end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!dp_valid) begin
            if (n_reg != 2'd3) begin
              n_reg     <= n_reg + 2'd1;
              state_reg <= ST_ISSUE;
            end else if (t_reg != tlen_reg - T_W'(1)) begin
              n_reg     <= '0;
              t_reg     <= t_reg + T_W'(1);
              state_reg <= ST_FETCH;
            end else begin
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Clear and start may coincide; the clear lands on the same edge the sweep
  // begins, well before the first accumulate.
  assign bank_clr = (state_reg == ST_IDLE) && clr_acc;
  assign bank_wr  = (state_reg == ST_WAIT) && dp_valid;

  assign op_req      = (state_reg == ST_FETCH);
  assign op_t        = t_reg;
  assign dp_en       = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign dp_n        = n_reg;
  assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE) ||
                       (state_reg == ST_WAIT)  || (state_reg == ST_DRAIN);
  assign done        = (state_reg == ST_DONE);
  assign err_timeout = err_reg;

  dh_acc_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bank_clr),
    .wr_en   (bank_wr),
    .wr_row  (n_reg),
    .wr_r0   (dp_r0),
    .wr_r1   (dp_r1),
    .wr_r2   (dp_r2),
    .wr_r3   (dp_r3),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
